// File: rtl/pwm_dead_time.sv
// Complementary high/low gate drive with programmable dead time between drive changes.
// Optional latched fault shutdown is built when PWM_DT_FAULT_EN is defined.
module pwm_dead_time #(
    parameter  int unsigned DT_MAX = 255,
    localparam int unsigned DW     = $clog2(DT_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          pwm,
    input  logic [DW-1:0] dt,
    input  logic          fault,
    input  logic          fault_clr,
    output logic          hi,
    output logic          lo,
    output logic          dead,
    output logic          fault_latched
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DT_HI,
        S_HI,
        S_DT_LO,
        S_LO,
        S_FLT
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          hi_q, hi_d;
    logic          lo_q, lo_d;
    logic          dead_q, dead_d;
    logic          flt_q, flt_d;

    logic          fault_hit_c;
    logic          clr_ok_c;
    logic          start_c;
    logic          done_c;
    logic [DW-1:0] cnt_inc_c;

`ifdef PWM_DT_FAULT_EN
    assign fault_hit_c = fault;
    assign clr_ok_c    = fault_clr;
`else
    assign fault_hit_c = 1'b0;
    assign clr_ok_c    = 1'b0;
    logic unused_fault_in;
    assign unused_fault_in = fault ^ fault_clr;
`endif

    // Dead-time counter saturates rather than wrapping
    assign cnt_inc_c = (cnt_q == DW'(DT_MAX)) ? cnt_q : cnt_q + DW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dead_d  = dead_q;
        flt_d   = flt_q;
        start_c = 1'b0;
        done_c  = 1'b0;

        if (fault_hit_c) begin
            state_d = S_FLT;
            cnt_d   = '0;
            hi_d    = 1'b0;
            lo_d    = 1'b0;
            dead_d  = 1'b0;
            flt_d   = 1'b1;
        end else if (state_q == S_FLT) begin
            if (clr_ok_c) begin
                state_d = S_IDLE;
                flt_d   = 1'b0;
            end
        end else if (!en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            hi_d    = 1'b0;
            lo_d    = 1'b0;
            dead_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE:  start_c = 1'b1;
                S_LO:    start_c = pwm;
                S_HI:    start_c = !pwm;
                S_DT_HI: begin
                    if (!pwm)            start_c = 1'b1;
                    else if (cnt_q >= dt) done_c = 1'b1;
                    else                 cnt_d   = cnt_inc_c;
                end
                S_DT_LO: begin
                    if (pwm)             start_c = 1'b1;
                    else if (cnt_q >= dt) done_c = 1'b1;
                    else                 cnt_d   = cnt_inc_c;
                end
                default: ;
            endcase

            // A new drive target always restarts a full dead time; dt==0 drives at once
            if (start_c && (dt != '0)) begin
                state_d = pwm ? S_DT_HI : S_DT_LO;
                cnt_d   = DW'(1);
                hi_d    = 1'b0;
                lo_d    = 1'b0;
                dead_d  = 1'b1;
            end else if (start_c || done_c) begin
                state_d = pwm ? S_HI : S_LO;
                cnt_d   = '0;
                hi_d    = pwm;
                lo_d    = !pwm;
                dead_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= 1'b0;
            lo_q    <= 1'b0;
            dead_q  <= 1'b0;
            flt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dead_q  <= dead_d;
            flt_q   <= flt_d;
        end
    end

    assign hi            = hi_q;
    assign lo            = lo_q;
    assign dead          = dead_q;
    assign fault_latched = flt_q;

endmodule

// File: tb/tb_pwm_dead_time.sv
// Self-checking bench for pwm_dead_time: edge-indexed reference model plus directed literal checks.
// Fault expectations follow PWM_DT_FAULT_EN, matching the build of the design.
module tb_pwm_dead_time;

    localparam int unsigned DT_MAX = 255;
    localparam int unsigned DW     = $clog2(DT_MAX + 1);
`ifdef PWM_DT_FAULT_EN
    localparam bit FLT_EN = 1'b1;
`else
    localparam bit FLT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          pwm = 1'b0;
    logic [DW-1:0] dt = '0;
    logic          fault = 1'b0;
    logic          fault_clr = 1'b0;
    logic          hi, lo, dead, fault_latched;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    pwm_dead_time #(.DT_MAX(DT_MAX)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .pwm           (pwm),
        .dt            (dt),
        .fault         (fault),
        .fault_clr     (fault_clr),
        .hi            (hi),
        .lo            (lo),
        .dead          (dead),
        .fault_latched (fault_latched)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: the drive is granted once dt edges have passed since the last target change
    bit m_on = 0, m_drv = 0, m_tgt = 0, m_flt = 0;
    int m_e = 0, m_start = 0;
    bit e_hi = 0, e_lo = 0, e_dead = 0, e_flt = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_on  = 0;
            m_drv = 0;
            m_flt = 0;
        end else begin
            m_e++;
            if (FLT_EN && fault) begin
                m_flt = 1;
                m_on  = 0;
                m_drv = 0;
            end else if (m_flt) begin
                if (fault_clr) m_flt = 0;
            end else if (!en) begin
                m_on  = 0;
                m_drv = 0;
            end else if (!m_on || (pwm != m_tgt)) begin
                m_on    = 1;
                m_tgt   = pwm;
                m_start = m_e;
                m_drv   = (dt == 0);
            end else if (!m_drv && ((m_e - m_start) >= int'(dt))) begin
                m_drv = 1;
            end
        end
        e_hi   = m_on && m_drv && m_tgt;
        e_lo   = m_on && m_drv && !m_tgt;
        e_dead = m_on && !m_drv;
        e_flt  = m_flt;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_hi", int'(hi), int'(e_hi));
            chk("model_lo", int'(lo), int'(e_lo));
            chk("model_dead", int'(dead), int'(e_dead));
            chk("model_fault_latched", int'(fault_latched), int'(e_flt));
            chk("no_overlap", int'(hi && lo), 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        bit en;
        bit pwm;
        int dt;
        int n;
    } vec_t;

    vec_t vecs[10] = '{
        '{1'b1, 1'b0, 3, 6},
        '{1'b1, 1'b1, 3, 2},
        '{1'b1, 1'b0, 3, 1},
        '{1'b1, 1'b1, 2, 1},
        '{1'b1, 1'b1, 7, 9},
        '{1'b1, 1'b0, 2, 1},
        '{1'b1, 1'b0, 6, 4},
        '{1'b0, 1'b1, 6, 2},
        '{1'b1, 1'b1, 0, 3},
        '{1'b1, 1'b0, 4, 7}
    };

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("reset_hi", int'(hi), 0);
        chk("reset_lo", int'(lo), 0);
        chk("reset_dead", int'(dead), 0);
        chk("reset_fault_latched", int'(fault_latched), 0);
        @(negedge clk);
        rst    = 1'b0;
        chk_on = 1'b1;

        // dt=5 rising transition out of LO
        en = 1'b1; dt = DW'(5); pwm = 1'b0;
        tick(8);
        chk("t2_lo_steady", int'(lo), 1);
        pwm = 1'b1;
        tick(1);
        chk("t2_lo_off_at_k", int'(lo), 0);
        chk("t2_dead_at_k", int'(dead), 1);
        tick(4);
        chk("t2_hi_off_k4", int'(hi), 0);
        chk("t2_dead_k4", int'(dead), 1);
        tick(1);
        chk("t2_hi_on_k5", int'(hi), 1);
        chk("t2_dead_off_k5", int'(dead), 0);

        // Asynchronous reset between clock edges while in HI
        #2 rst = 1'b1;
        #1;
        chk("t1_async_hi", int'(hi), 0);
        chk("t1_async_lo", int'(lo), 0);
        @(negedge clk);
        rst = 1'b0;

        // dt=0: drives switch on the sampling edge
        dt = DW'(0); pwm = 1'b0;
        tick(3);
        for (int i = 0; i < 4; i++) begin
            pwm = ~pwm;
            tick(1);
            chk("t3_hi_follows", int'(hi), int'(pwm));
            chk("t3_lo_follows", int'(lo), int'(!pwm));
            tick(2);
        end

        // dt=8 with a reversal inside the dead time
        dt = DW'(8); pwm = 1'b0;
        tick(2);
        pwm = 1'b1;
        tick(3);
        pwm = 1'b0;
        tick(8);
        chk("t4_lo_still_off", int'(lo), 0);
        chk("t4_hi_never", int'(hi), 0);
        tick(1);
        chk("t4_lo_back", int'(lo), 1);

        // dt lowered from 10 to 4 while the count is at 6
        dt = DW'(10);
        pwm = 1'b1;
        tick(6);
        chk("t5_hi_off_cnt6", int'(hi), 0);
        chk("t5_dead_cnt6", int'(dead), 1);
        dt = DW'(4);
        tick(1);
        chk("t5_hi_on_after_lower", int'(hi), 1);

        // en drop and re-enable with a full dead time
        en = 1'b0;
        tick(1);
        chk("en0_hi", int'(hi), 0);
        chk("en0_dead", int'(dead), 0);
        dt = DW'(3); en = 1'b1;
        tick(3);
        chk("reen_hi_off", int'(hi), 0);
        chk("reen_dead", int'(dead), 1);
        tick(1);
        chk("reen_hi_on", int'(hi), 1);

        // Fault shutdown and clear
        fault = 1'b1;
        tick(1);
        if (FLT_EN) begin
            chk("t6_flt_hi", int'(hi), 0);
            chk("t6_flt_latched", int'(fault_latched), 1);
            fault_clr = 1'b1;
            tick(2);
            chk("t6_clr_ignored", int'(fault_latched), 1);
            fault = 1'b0;
            tick(1);
            chk("t6_cleared", int'(fault_latched), 0);
            chk("t6_idle_hi", int'(hi), 0);
            fault_clr = 1'b0;
            tick(1);
            chk("t6_dead_start", int'(dead), 1);
            tick(2);
            chk("t6_hi_wait", int'(hi), 0);
            tick(1);
            chk("t6_hi_on", int'(hi), 1);
        end else begin
            chk("t6_nofault_hi", int'(hi), 1);
            chk("t6_nofault_latched", int'(fault_latched), 0);
            fault_clr = 1'b1;
            tick(2);
            chk("t6_nofault_hi2", int'(hi), 1);
            fault = 1'b0; fault_clr = 1'b0;
            pwm = 1'b0;
            tick(1);
            chk("t6_nofault_follow_hi", int'(hi), 0);
            chk("t6_nofault_dead", int'(dead), 1);
            tick(3);
            chk("t6_nofault_follow_lo", int'(lo), 1);
        end
        fault = 1'b0; fault_clr = 1'b0;

        // Mixed directed vectors, checked by the model every cycle
        foreach (vecs[i]) begin
            en  = vecs[i].en;
            pwm = vecs[i].pwm;
            dt  = DW'(vecs[i].dt);
            tick(vecs[i].n);
        end
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
